// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one fpu between N_REQ clients, round-robin by default.
// Define FPU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module fpu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WAIT_CYCLES = 40,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] op_a,
    input  logic [32*N_REQ-1:0] op_b,
    output logic [N_REQ-1:0]    done,
    output logic [31:0]         result,
    output logic [3:0]          status,
    output logic [ID_W-1:0]     resp_id,
    output logic                busy,
    output logic                fpu_start,
    output logic [31:0]         fpu_op_a,
    output logic [31:0]         fpu_op_b,
    input  logic [31:0]         fpu_data,
    input  logic [3:0]          fpu_status
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    state_t          state;
    logic [7:0]      counter;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] pick_id;
    logic            pick_ok;

`ifndef FPU_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] ptr;
`endif

    // Descending scan so the candidate closest to the search start wins.
    always_comb begin
        int j;
        j       = 0;
        pick_id = '0;
        pick_ok = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
            j = i;
`else
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
`endif
            if (req[j]) begin
                pick_id = ID_W'(j);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            gnt_id    <= '0;
            done      <= '0;
            result    <= '0;
            status    <= '0;
            resp_id   <= '0;
            busy      <= 1'b0;
            fpu_start <= 1'b0;
            fpu_op_a  <= '0;
            fpu_op_b  <= '0;
`ifndef FPU_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            done      <= '0;
            fpu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_ok) begin
                        fpu_op_a  <= op_a[32*pick_id +: 32];
                        fpu_op_b  <= op_b[32*pick_id +: 32];
                        gnt_id    <= pick_id;
                        fpu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    counter <= 8'(WAIT_CYCLES - 1);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (counter == 8'd0) begin
                        state <= CAPTURE;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                CAPTURE: begin
                    result  <= fpu_data;
                    status  <= fpu_status;
                    resp_id <= gnt_id;
                    done    <= N_REQ'(1) << gnt_id;
                    state   <= RESP;
                end
                RESP: begin
`ifndef FPU_ARB_FIXED_PRIO_EN
                    if (gnt_id == ID_W'(N_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt_id + 1'b1;
                    end
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: scoreboard bench for fpu_arbiter with a stand-in fpu
// (32-cycle latency, integer add, flags {carry, zero, msb, 1}).
module tb_fpu_arbiter;

    localparam int N   = 4;
    localparam int W   = 40;
    localparam int LAT = 32;
    localparam int LT  = W + 2;
    localparam int PER = W + 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req;
    logic [32*N-1:0] op_a;
    logic [32*N-1:0] op_b;
    logic [N-1:0]   done;
    logic [31:0]    result;
    logic [3:0]     status;
    logic [1:0]     resp_id;
    logic           busy;
    logic           fpu_start;
    logic [31:0]    fpu_op_a;
    logic [31:0]    fpu_op_b;
    logic [31:0]    fpu_data;
    logic [3:0]     fpu_status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  st;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fpu_arbiter #(.N_REQ(N), .WAIT_CYCLES(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .done       (done),
        .result     (result),
        .status     (status),
        .resp_id    (resp_id),
        .busy       (busy),
        .fpu_start  (fpu_start),
        .fpu_op_a   (fpu_op_a),
        .fpu_op_b   (fpu_op_b),
        .fpu_data   (fpu_data),
        .fpu_status (fpu_status)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Stand-in fpu: garbage right after start, answer LAT cycles later,
    // computed from the operand bus at that moment.
    logic [32:0] fsum;
    int          fcnt;
    assign fsum = {1'b0, fpu_op_a} + {1'b0, fpu_op_b};

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            fcnt       <= 0;
            fpu_data   <= '0;
            fpu_status <= '0;
        end else if (fpu_start) begin
            fcnt       <= LAT;
            fpu_data   <= 32'hDEADBEEF;
            fpu_status <= 4'hE;
        end else if (fcnt == 1) begin
            fcnt       <= 0;
            fpu_data   <= fsum[31:0];
            fpu_status <= {fsum[32], fsum[31:0] == 32'd0, fsum[31], 1'b1};
        end else if (fcnt > 1) begin
            fcnt <= fcnt - 1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(int id, logic [31:0] res, logic [3:0] st, int c);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.st  = st;
        e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b1 && done !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%b required=0000 cyc=%0d",
                         done, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_onehot", 32'(done), 32'(1) << mon_e.id);
                chk("resp_id", 32'(resp_id), 32'(mon_e.id));
                chk("result", result, mon_e.res);
                chk("status", 32'(status), 32'(mon_e.st));
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_status"}, 32'(status), 32'd0);
        chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(fpu_start), 32'd0);
        chk({tag, "_op_a"}, fpu_op_a, 32'd0);
        chk({tag, "_op_b"}, fpu_op_b, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = '0;
        #1;
        check_zero("rst");
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_until(int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic wait_drain(int limit);
        int t;
        t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int k;
        int bad;
        req  = '0;
        op_a = '0;
        op_b = '0;

        do_reset();

        // Single request from requester 1
        @(negedge clock);
        op_a[63:32] = 32'h40800000;
        op_b[63:32] = 32'h40800000;
        req = 4'b0010;
        k = cyc + 1;
        push(1, 32'h81000000, 4'h3, k + LT);
        @(negedge clock);
        chk("t1_start_hi", 32'(fpu_start), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_op_a", fpu_op_a, 32'h40800000);
        @(negedge clock);
        chk("t1_start_lo", 32'(fpu_start), 32'd0);
        req = '0;
        wait_drain(200);

        // All four requesting from reset
        do_reset();
        @(negedge clock);
        op_a = {32'h12345678, 32'h80000000, 32'h40800000, 32'h00000001};
        op_b = {32'h11111111, 32'h80000000, 32'h40800000, 32'h00000002};
        req = 4'b1111;
        k = cyc + 1;
        push(0, 32'h00000003, 4'h1, k + LT);
        push(1, 32'h81000000, 4'h3, k + LT + PER);
        push(2, 32'h00000000, 4'hD, k + LT + 2 * PER);
        push(3, 32'h23456789, 4'h1, k + LT + 3 * PER);
        push(0, 32'h00000003, 4'h1, k + LT + 4 * PER);
        wait_until(k + LT + 4 * PER);
        req = '0;
        wait_drain(300);

        // Operand hold: source changes after the grant are ignored
        @(negedge clock);
        op_a[31:0] = 32'h00000005;
        op_b[31:0] = 32'h00000006;
        req = 4'b0001;
        k = cyc + 1;
        push(0, 32'h0000000B, 4'h1, k + LT);
        repeat (2) @(negedge clock);
        op_a[31:0] = 32'hFFFFFFFF;
        req = '0;
        repeat (5) @(negedge clock);
        chk("t3_op_a_hold", fpu_op_a, 32'h00000005);
        chk("t3_op_b_hold", fpu_op_b, 32'h00000006);
        wait_drain(200);

        // Reset during WAIT aborts without a done
        @(negedge clock);
        op_a[31:0] = 32'h00000001;
        op_b[31:0] = 32'h00000002;
        req = 4'b0001;
        repeat (10) @(negedge clock);
        chk("t4_busy_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        req   = '0;
        #1;
        check_zero("t4_abort");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (60) @(negedge clock);
        req = 4'b0001;
        k = cyc + 1;
        push(0, 32'h00000003, 4'h1, k + LT);
        repeat (2) @(negedge clock);
        req = '0;
        wait_drain(200);

        // Idle: nothing moves, result/status hold
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || fpu_start !== 1'b0) bad++;
        end
        chk("t5_idle_quiet", 32'(bad), 32'd0);
        chk("t5_result_hold", result, 32'h00000003);
        chk("t5_status_hold", 32'(status), 32'h1);

        // req 1001 held: alternation vs fixed priority
        do_reset();
        @(negedge clock);
        op_a = {32'h12345678, 32'h0, 32'h0, 32'h00000001};
        op_b = {32'h11111111, 32'h0, 32'h0, 32'h00000002};
        req = 4'b1001;
        k = cyc + 1;
        for (int i = 0; i < 4; i++) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
            push(0, 32'h00000003, 4'h1, k + LT + i * PER);
`else
            if (i % 2 == 0) push(0, 32'h00000003, 4'h1, k + LT + i * PER);
            else            push(3, 32'h23456789, 4'h1, k + LT + i * PER);
`endif
        end
        wait_until(k + LT + 3 * PER);
        req = '0;
        wait_drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
